// File: rtl/accum_buffer_pkg.sv
// Shared types and the lane-wise wrapping adder for the multibank accumulation buffer.
// Widths are sized for the largest supported configuration; users cast down to their own widths.
package accum_buffer_pkg;

  localparam int MAX_DATA_WIDTH     = 256;
  localparam int MAX_ADDR_WIDTH     = 16;
  localparam int MAX_BANK_IDX_WIDTH = 8;

  typedef logic [MAX_DATA_WIDTH-1:0]     wide_t;
  typedef logic [MAX_ADDR_WIDTH-1:0]     adr_t;
  typedef logic [MAX_BANK_IDX_WIDTH-1:0] bank_idx_t;

  // S1 stage: sum carries the captured addend; the bank operand is folded in combinationally.
  typedef struct packed {
    logic      valid;
    bank_idx_t bank;
    adr_t      adr;
    wide_t     sum;
  } s1_t;

  // Carry is killed at every lane boundary so each lane wraps independently.
  function automatic wide_t lane_add(input wide_t a, input wide_t b,
                                     input int lanes, input int lane_width);
    wide_t s;
    logic  c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i % lane_width == 0) c = 1'b0;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      if (i >= lanes * lane_width) s[i] = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/accum_bank.sv
// Single-bank 1R1W memory, registered read; a same-edge read of a written word returns the old value.
// Read data valid one cycle after re and held while re is low; no flow control.
module accum_bank #(
  parameter int DEPTH = 36,
  parameter int AW    = 6,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdat,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdat;
    if (re) rdat <= mem[radr];
  end

endmodule

// File: rtl/multibank_accumulation_buffer.sv
// Ring of accumulation banks with in-place lane-wise accumulate and clear-on-read writeback.
// Reads valid one cycle after enable; accumulate is 2-stage at one per cycle, never stalls (a colliding wen is dropped and flagged).
module multibank_accumulation_buffer
  import accum_buffer_pkg::*;
#(
  parameter  int LANES           = 4,
  parameter  int LANE_WIDTH      = 16,
  parameter  int DATA_WIDTH      = LANES * LANE_WIDTH,
  parameter  int NUM_BANKS       = 2,
  parameter  int BANK_ADDR_WIDTH = 6,
  parameter  int BANK_DEPTH      = 36,
  localparam int BW              = $clog2(NUM_BANKS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       switch_banks,
  input  logic                       ren,
  input  logic [BANK_ADDR_WIDTH-1:0] radr,
  output logic [DATA_WIDTH-1:0]      rdata,
  input  logic                       wen,
  input  logic [BANK_ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       acc_en,
  input  logic [BANK_ADDR_WIDTH-1:0] acc_adr,
  input  logic [DATA_WIDTH-1:0]      acc_data,
  input  logic                       ren_wb,
  input  logic [BANK_ADDR_WIDTH-1:0] radr_wb,
  input  logic                       clear_wb,
  output logic [DATA_WIDTH-1:0]      rdata_wb,
  output logic [BW-1:0]              acc_bank,
  output logic                       wr_conflict
);

  logic [BW-1:0]         a_q, a_nxt, wb_idx;
  s1_t                   s1_q;
  logic                  s1_wr;
  logic                  fwd_q;
  wide_t                 fwd_dat_q, s1_opnd, s1_sum;
  logic                  acc_hit, rd_hit;
  logic                  rd_vld_q, rd_fwd_q, wb_vld_q;
  logic [BW-1:0]         rd_bank_q, wb_bank_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_wb_hold_q;
  logic [DATA_WIDTH-1:0] bank_rdat [NUM_BANKS];

  assign a_nxt    = (a_q == BW'(NUM_BANKS - 1)) ? '0 : a_q + BW'(1);
  assign wb_idx   = (a_q == '0) ? BW'(NUM_BANKS - 1) : a_q - BW'(1);
  assign acc_bank = a_q;

  // Reset in the same cycle suppresses the pending S1 write.
  assign s1_wr   = s1_q.valid && !rst;
  assign s1_opnd = fwd_q ? fwd_dat_q : wide_t'(bank_rdat[s1_q.bank[BW-1:0]]);
  assign s1_sum  = lane_add(s1_opnd, s1_q.sum, LANES, LANE_WIDTH);

  assign acc_hit = s1_q.valid && (s1_q.bank == bank_idx_t'(a_q)) && (s1_q.adr == adr_t'(acc_adr));
  assign rd_hit  = s1_q.valid && (s1_q.bank == bank_idx_t'(a_q)) && (s1_q.adr == adr_t'(radr));

  assign rdata    = !rd_vld_q ? rdata_hold_q :
                    rd_fwd_q  ? fwd_dat_q[DATA_WIDTH-1:0] : bank_rdat[rd_bank_q];
  assign rdata_wb = wb_vld_q ? bank_rdat[wb_bank_q] : rdata_wb_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q             <= '0;
      s1_q            <= '0;
      fwd_q           <= 1'b0;
      fwd_dat_q       <= '0;
      rd_vld_q        <= 1'b0;
      rd_fwd_q        <= 1'b0;
      rd_bank_q       <= '0;
      wb_vld_q        <= 1'b0;
      wb_bank_q       <= '0;
      rdata_hold_q    <= '0;
      rdata_wb_hold_q <= '0;
      wr_conflict     <= 1'b0;
    end else begin
      if (switch_banks) a_q <= a_nxt;
      s1_q.valid <= acc_en;
      if (acc_en) begin
        s1_q.bank <= bank_idx_t'(a_q);
        s1_q.adr  <= adr_t'(acc_adr);
        s1_q.sum  <= wide_t'(acc_data);
      end
      fwd_q           <= acc_en && acc_hit;
      fwd_dat_q       <= s1_sum;
      rd_vld_q        <= ren && !acc_en;
      rd_fwd_q        <= ren && !acc_en && rd_hit;
      rd_bank_q       <= a_q;
      wb_vld_q        <= ren_wb;
      wb_bank_q       <= wb_idx;
      rdata_hold_q    <= rdata;
      rdata_wb_hold_q <= rdata_wb;
      wr_conflict     <= wen && s1_wr;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                       is_acc, is_wb, re, we;
    logic [BANK_ADDR_WIDTH-1:0] ra, wa;
    logic [DATA_WIDTH-1:0]      wd;

    // The S1 write owns a bank's write port, even after that bank has rotated to writeback.
    always_comb begin
      is_acc = (a_q == BW'(b));
      is_wb  = (wb_idx == BW'(b));
      re     = (is_acc && (acc_en || ren)) || (is_wb && ren_wb);
      ra     = is_wb ? radr_wb : (acc_en ? acc_adr : radr);
      we     = 1'b0;
      wa     = wadr;
      wd     = wdata;
      if (s1_wr && (s1_q.bank == bank_idx_t'(b))) begin
        we = 1'b1;
        wa = s1_q.adr[BANK_ADDR_WIDTH-1:0];
        wd = s1_sum[DATA_WIDTH-1:0];
      end else if (is_acc && wen && !s1_wr) begin
        we = 1'b1;
      end else if (is_wb && ren_wb && clear_wb) begin
        we = 1'b1;
        wa = radr_wb;
        wd = '0;
      end
    end

    accum_bank #(
      .DEPTH (BANK_DEPTH),
      .AW    (BANK_ADDR_WIDTH),
      .DW    (DATA_WIDTH)
    ) u_bank (
      .clk  (clk),
      .re   (re),
      .radr (ra),
      .rdat (bank_rdat[b]),
      .we   (we),
      .wadr (wa),
      .wdat (wd)
    );
  end

endmodule

// File: tb/tb_multibank_accumulation_buffer.sv
// Bench for multibank_accumulation_buffer with a three-bank ring: lane-add vector table plus
// hand sequences for forwarding, write conflict, ring rotation, clear-on-read and reset.
module tb_multibank_accumulation_buffer;

  localparam int LANES = 4;
  localparam int LW    = 16;
  localparam int DW    = LANES * LW;
  localparam int NB    = 3;
  localparam int AW    = 6;
  localparam int DEPTH = 36;
  localparam int BW    = $clog2(NB);

  logic          clk = 1'b0;
  logic          rst, switch_banks, ren, wen, acc_en, ren_wb, clear_wb;
  logic [AW-1:0] radr, wadr, acc_adr, radr_wb;
  logic [DW-1:0] wdata, acc_data, rdata, rdata_wb;
  logic [BW-1:0] acc_bank;
  logic          wr_conflict;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] val;
    string         name;
  } exp_t;
  exp_t rd_q[$];
  exp_t wb_q[$];

  typedef struct {
    logic [DW-1:0] init;
    logic [DW-1:0] addend;
    logic [DW-1:0] sum;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  multibank_accumulation_buffer #(
    .LANES           (LANES),
    .LANE_WIDTH      (LW),
    .NUM_BANKS       (NB),
    .BANK_ADDR_WIDTH (AW),
    .BANK_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .switch_banks (switch_banks),
    .ren          (ren),
    .radr         (radr),
    .rdata        (rdata),
    .wen          (wen),
    .wadr         (wadr),
    .wdata        (wdata),
    .acc_en       (acc_en),
    .acc_adr      (acc_adr),
    .acc_data     (acc_data),
    .ren_wb       (ren_wb),
    .radr_wb      (radr_wb),
    .clear_wb     (clear_wb),
    .rdata_wb     (rdata_wb),
    .acc_bank     (acc_bank),
    .wr_conflict  (wr_conflict)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    switch_banks = 1'b0;
    ren = 1'b0;      radr = '0;
    wen = 1'b0;      wadr = '0;     wdata = '0;
    acc_en = 1'b0;   acc_adr = '0;  acc_data = '0;
    ren_wb = 1'b0;   radr_wb = '0;  clear_wb = 1'b0;
  endtask

  // One clock: reads issued this cycle are scored against the queue one cycle later.
  task automatic step();
    logic was_rd, was_wb;
    exp_t e;
    was_rd = ren;
    was_wb = ren_wb;
    @(posedge clk);
    #1;
    if (was_rd) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_queue_underflow: got read with no expectation");
      end else begin
        e = rd_q.pop_front();
        check(e.name, rdata, e.val);
      end
    end
    if (was_wb) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_queue_underflow: got read with no expectation");
      end else begin
        e = wb_q.pop_front();
        check(e.name, rdata_wb, e.val);
      end
    end
    clear_inputs();
  endtask

  task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen = 1'b1; wadr = a; wdata = d;
  endtask

  task automatic issue_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    ren = 1'b1; radr = a;
    rd_q.push_back('{val: exp, name: name});
  endtask

  task automatic issue_rd_wb(input logic [AW-1:0] a, input logic clr, input logic [DW-1:0] exp, input string name);
    ren_wb = 1'b1; radr_wb = a; clear_wb = clr;
    wb_q.push_back('{val: exp, name: name});
  endtask

  task automatic issue_acc(input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_en = 1'b1; acc_adr = a; acc_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'hFFFF_0000_7FFF_0001, 64'h0001_0001_0001_FFFF, 64'h0000_0001_8000_0000};
    vecs[1] = '{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 64'h0011_0022_0033_0044};
    vecs[2] = '{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 64'h0000_0000_0000_0000};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};
    vecs[4] = '{64'h00FF_FF00_0F0F_F0F0, 64'hFF01_0100_F0F1_0F10, 64'h0000_0000_0000_0000};
    vecs[5] = '{64'h7FFF_FFFF_0000_0001, 64'h0001_0001_FFFF_FFFF, 64'h8000_0000_FFFF_0000};

    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset_rdata", rdata, '0);
    check("reset_rdata_wb", rdata_wb, '0);
    check("reset_wr_conflict", DW'(wr_conflict), '0);
    check("reset_acc_bank", DW'(acc_bank), '0);
    rst = 1'b0;
    step();

    // Plain write then read, bank 0.
    issue_wr(6'd2, 64'h0001_0002_0003_0004); step();
    check("plain_wr_no_conflict", DW'(wr_conflict), '0);
    issue_rd(6'd2, 64'h0001_0002_0003_0004, "plain_rd_adr2"); step();
    check("acc_bank_start", DW'(acc_bank), '0);

    // Back-to-back accumulate to one address exercises S1->S0 forwarding.
    issue_wr(6'd5, '0); step();
    for (int i = 0; i < 3; i++) begin
      issue_acc(6'd5, 64'h0001_0001_0001_0001); step();
    end
    issue_rd(6'd5, 64'h0003_0003_0003_0003, "acc3_forwarded_rd"); step();
    issue_rd(6'd5, 64'h0003_0003_0003_0003, "acc3_mem_rd"); step();

    // wen colliding with an S1 write is dropped and flagged one cycle later.
    issue_wr(6'd9, 64'h1111_2222_3333_4444); step();
    issue_acc(6'd5, '0); step();
    issue_wr(6'd9, 64'hDEAD_BEEF_DEAD_BEEF); step();
    check("conflict_pulse", DW'(wr_conflict), DW'(1));
    step();
    check("conflict_pulse_ends", DW'(wr_conflict), '0);
    issue_rd(6'd9, 64'h1111_2222_3333_4444, "conflict_mem_unchanged"); step();

    // Lane-wise wrap table; first read lands while S1 is writing (forwarded), second from memory.
    for (int i = 0; i < 6; i++) begin
      issue_wr(AW'(10 + i), vecs[i].init); step();
      issue_acc(AW'(10 + i), vecs[i].addend); step();
      issue_rd(AW'(10 + i), vecs[i].sum, $sformatf("lane_add_fwd_%0d", i)); step();
      issue_rd(AW'(10 + i), vecs[i].sum, $sformatf("lane_add_mem_%0d", i)); step();
    end

    // Ring rotation; the write issued with the switch still lands in the old bank.
    issue_wr(6'd0, 64'hA); switch_banks = 1'b1; step();
    check("ring_acc_bank_1", DW'(acc_bank), DW'(1));
    issue_wr(6'd0, 64'hB); step();
    switch_banks = 1'b1; step();
    check("ring_acc_bank_2", DW'(acc_bank), DW'(2));
    issue_rd_wb(6'd0, 1'b0, 64'hB, "ring_wb_bank1"); issue_wr(6'd3, 64'h77); step();
    switch_banks = 1'b1; step();
    check("ring_wrap_acc_bank_0", DW'(acc_bank), '0);
    issue_rd(6'd0, 64'hA, "ring_bank0_again"); step();

    // Clear-on-read of bank 2, then bring it round and accumulate into the cleared word.
    issue_rd_wb(6'd3, 1'b1, 64'h77, "clear_rd_old_value"); step();
    issue_rd_wb(6'd3, 1'b0, '0, "clear_word_zeroed"); step();
    switch_banks = 1'b1; step();
    switch_banks = 1'b1; step();
    check("clear_bank_is_acc", DW'(acc_bank), DW'(2));
    issue_acc(6'd3, 64'h5); step();
    issue_rd(6'd3, 64'h5, "acc_after_clear_fwd"); step();
    issue_rd(6'd3, 64'h5, "acc_after_clear_mem"); step();

    // S1 write pending across a switch goes to the now-writeback bank; same-cycle ren_wb sees the old value.
    issue_acc(6'd3, 64'h10); switch_banks = 1'b1; step();
    check("switch_pending_acc_bank", DW'(acc_bank), '0);
    issue_rd_wb(6'd3, 1'b0, 64'h5, "switch_pending_old"); step();
    issue_rd_wb(6'd3, 1'b0, 64'h15, "switch_pending_new"); step();

    // Reset while an accumulate is in S1 discards it.
    switch_banks = 1'b1; step();
    issue_wr(6'd20, 64'h100); step();
    issue_acc(6'd20, 64'h1); step();
    rst = 1'b1; step();
    rst = 1'b0;
    check("midrst_rdata", rdata, '0);
    check("midrst_rdata_wb", rdata_wb, '0);
    check("midrst_acc_bank", DW'(acc_bank), '0);
    switch_banks = 1'b1; step();
    issue_rd(6'd20, 64'h100, "midrst_write_discarded"); step();
    step();

    checks++;
    if (rd_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", rd_q.size(), wb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
